force_pair_scheduler: RTL
=========================

FORCE_PAIR_SCHEDULER -- requirements
Module: force_pair_scheduler

Interface
REQ-001 Parameter N, default 16: number of bodies; N>=1.
REQ-002 Parameter LATENCY, default 6: fixed fc_valid_in-to-fc_valid_out delay of the force unit, in cycles.
REQ-003 Parameter ADDR_WIDTH, default $clog2(N) (min 1): body index and RAM address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin one full N-body force pass; sampled only in IDLE.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse at pass completion.
REQ-009 err  out  1  sticky protocol error flag.
REQ-010 rden_a, rden_b  out  1 each  body RAM read enables; read data valid the cycle after.
REQ-011 addr_a, addr_b  out  ADDR_WIDTH each  body RAM read addresses (a = body i, b = body j).
REQ-012 q_a, q_b  in  80 each  body RAM read data, {x,y,vx,vy,mass}, 16 bits each.
REQ-013 fc_valid_in  out  1  pair valid to force unit.
REQ-014 fc_body_i, fc_body_j  out  80 each  pair operands.
REQ-015 fc_valid_out  in  1  force result valid.
REQ-016 fc_force_x, fc_force_y  in  32 each  signed pair force.
REQ-017 out_valid  out  1; out_ready  in  1  accumulated-force handshake.
REQ-018 out_index  out  ADDR_WIDTH; out_force_x, out_force_y  out  32 each  total force on body out_index.

Function
REQ-019 States: IDLE, FETCH_I, LOAD_I, ISSUE, DRAIN, EMIT, DONE.
REQ-020 IDLE: on start go to FETCH_I with i=0; otherwise stay.
REQ-021 FETCH_I (1 cycle): rden_a=1, addr_a=i.
REQ-022 LOAD_I (1 cycle): register body_i <= q_a; clear j, issue counter, result counter, accumulators.
REQ-023 ISSUE: exactly N cycles, j=0..N-1. For j!=i: rden_b=1, addr_b=j. For j==i: no read, no issue.
REQ-024 ISSUE pipeline: the cycle after each read, fc_valid_in=1, fc_body_i=body_i, fc_body_j=q_b. fc_valid_in and fc_body_* are 0 otherwise.
REQ-025 After j=N-1, ISSUE goes to DRAIN.
REQ-026 Every fc_valid_out in ISSUE or DRAIN: accumulators += fc_force_x/y, 32-bit two's-complement, modulo 2^32 wrap, no saturation; result counter +1.
REQ-027 DRAIN goes to EMIT the cycle after result counter reaches N-1.
REQ-028 N==1: DRAIN goes to EMIT immediately; forces 0.
REQ-029 EMIT: out_valid=1; out_index=i; out_force_x/y=accumulators.
REQ-030 EMIT: all out_* held stable while out_ready=0; no RAM reads or force issues occur.
REQ-031 EMIT handshake (out_valid & out_ready): if i==N-1 go to DONE, else i+1 and go to FETCH_I.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE.
REQ-033 start is ignored while busy.
REQ-034 Pairs issued per pass: N*(N-1). Results emitted in order i=0..N-1. Throughput: one pair per cycle in ISSUE.
REQ-035 err set on:
- fc_valid_out outside ISSUE/DRAIN;
- fc_valid_out with result counter already N-1.
Such results are not accumulated.
REQ-036 err clears on reset or on an accepted start.

Reset
REQ-037 On reset:
- state IDLE; i, j, counters, accumulators, body_i cleared;
- all outputs 0 (busy, done, err, rden_*, addr_*, fc_*, out_*).
REQ-038 Reset mid-pass abandons the pass with no out_valid or done. Force unit shares reset; no stale result is accumulated after reset.

Verification
REQ-039 Assert reset 2 cycles -> every output 0; busy=0.
REQ-040 Setup: N=4, LATENCY=6, force model fx=1, fy=-1; start pulse. Required:
- 12 fc_valid_in, never with j==i;
- 4 emits, index 0..3, each fx=3, fy=0xFFFFFFFD;
- one done pulse after index 3.
REQ-041 Setup: out_ready=0 for 10 cycles at first EMIT. Required:
- out_valid and out_* stable throughout;
- rden_a/b=0 and fc_valid_in=0 throughout;
- run resumes identically to REQ-040 after release.
REQ-042 Model fx=0x7FFFFFFF, fy=0x80000000 -> each out_force_x=0x7FFFFFFD, out_force_y=0x80000000 (wrap).
REQ-043 Reset in ISSUE of i=1, then start -> output sequence identical to REQ-040; err=0.
REQ-044 Inject fc_valid_out in IDLE -> err=1 and accumulators unchanged; start during busy -> no effect; next accepted start clears err.

Source files
------------

// File: rtl/force_pair_scheduler.sv
// rtl/force_pair_scheduler.sv - all-pairs N-body force pass scheduler with per-body accumulation
//
// Purpose: for every body i, reads body i once, then streams every other body j
// past it into an external fixed-latency force unit (one pair per cycle),
// sums the returned pair forces and hands the total force on body i out over
// a valid/ready handshake. Bodies are emitted in order 0..N-1, then done pulses.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a pass (only sampled while idle)
//   busy, done, err            status: busy outside idle, done pulse, sticky error
//   rden_a/addr_a, q_a         body RAM port A (body i), data valid one cycle after read
//   rden_b/addr_b, q_b         body RAM port B (body j), data valid one cycle after read
//   fc_valid_in, fc_body_i/j   pair operands to the force unit
//   fc_valid_out, fc_force_x/y pair force returned by the force unit
//   out_valid/out_ready        accumulated force handshake
//   out_index, out_force_x/y   body index and its total force
module force_pair_scheduler #(
    parameter int N          = 16,
    parameter int LATENCY    = 6,
    parameter int ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  rden_a,
    output logic                  rden_b,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [79:0]           q_a,
    input  logic [79:0]           q_b,
    output logic                  fc_valid_in,
    output logic [79:0]           fc_body_i,
    output logic [79:0]           fc_body_j,
    input  logic                  fc_valid_out,
    input  logic [31:0]           fc_force_x,
    input  logic [31:0]           fc_force_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic [31:0]           out_force_x,
    output logic [31:0]           out_force_y
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_I,
        LOAD_I,
        ISSUE,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

    // A negative force-unit latency is not a meaningful configuration; such an
    // instance simply never leaves idle.
    localparam bit LATENCY_OK = (LATENCY >= 0);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   i;
    logic [ADDR_WIDTH-1:0]   j;
    logic [ADDR_WIDTH-1:0]   res_cnt;
    logic [31:0]             acc_x;
    logic [31:0]             acc_y;
    logic [79:0]             body_i;
    logic [ADDR_WIDTH-1:0]   i_next;
    logic [ADDR_WIDTH-1:0]   j_next;
    logic                    in_accum_window;

    always_comb begin
        i_next          = i + 1'b1;
        j_next          = j + 1'b1;
        in_accum_window = (state == ISSUE) || (state == DRAIN);
    end

    // Port B data arrives combinationally in the cycle after the read, which is
    // exactly the cycle the pair is presented, so the operand buses are gated
    // views rather than extra registers.
    assign fc_body_i = fc_valid_in ? body_i : 80'd0;
    assign fc_body_j = fc_valid_in ? q_b    : 80'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            res_cnt     <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            body_i      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rden_a      <= 1'b0;
            rden_b      <= 1'b0;
            addr_a      <= '0;
            addr_b      <= '0;
            fc_valid_in <= 1'b0;
            out_valid   <= 1'b0;
            out_index   <= '0;
            out_force_x <= '0;
            out_force_y <= '0;
        end else begin
            // Every B-port read becomes a pair issue one cycle later.
            fc_valid_in <= rden_b;

            // Results only count while a body is being worked on and while
            // fewer than N-1 have been seen; anything else is a protocol error
            // and is dropped.
            if (fc_valid_out) begin
                if (in_accum_window && (res_cnt != LAST_IDX)) begin
                    acc_x   <= acc_x + fc_force_x;
                    acc_y   <= acc_y + fc_force_y;
                    res_cnt <= res_cnt + 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start && LATENCY_OK) begin
                        state  <= FETCH_I;
                        busy   <= 1'b1;
                        i      <= '0;
                        rden_a <= 1'b1;
                        addr_a <= '0;
                        // A stray result in the same cycle still flags.
                        err    <= fc_valid_out;
                    end
                end

                FETCH_I: begin
                    state  <= LOAD_I;
                    rden_a <= 1'b0;
                    addr_a <= '0;
                end

                LOAD_I: begin
                    body_i  <= q_a;
                    j       <= '0;
                    res_cnt <= '0;
                    acc_x   <= '0;
                    acc_y   <= '0;
                    state   <= ISSUE;
                    // Body j=0 is read on the first ISSUE cycle unless it is i.
                    rden_b  <= (i != '0);
                    addr_b  <= '0;
                end

                ISSUE: begin
                    if (j == LAST_IDX) begin
                        state  <= DRAIN;
                        rden_b <= 1'b0;
                        addr_b <= '0;
                    end else begin
                        j      <= j_next;
                        rden_b <= (j_next != i);
                        addr_b <= (j_next != i) ? j_next : '0;
                    end
                end

                DRAIN: begin
                    // With N==1 the counter already equals N-1 on entry.
                    if (res_cnt == LAST_IDX) begin
                        state       <= EMIT;
                        out_valid   <= 1'b1;
                        out_index   <= i;
                        out_force_x <= acc_x;
                        out_force_y <= acc_y;
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_index   <= '0;
                        out_force_x <= '0;
                        out_force_y <= '0;
                        if (i == LAST_IDX) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            i      <= i_next;
                            state  <= FETCH_I;
                            rden_a <= 1'b1;
                            addr_a <= i_next;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
